// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero bypasses the iterations and reports all-ones quotient with dz set.
module divider_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dz
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, div_q;
   logic             qneg_q, rneg_q, dz_pend_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             dz_q;

   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   rem_shift;
   logic             fits, last;
   logic [WIDTH-1:0] rem_sub, rem_next, quo_next, q_final, r_final;

   always_comb begin
      a_neg  = sign & dataA[WIDTH-1];
      b_neg  = sign & dataB[WIDTH-1];
      b_zero = (dataB == '0);
      abs_a  = a_neg ? -dataA : dataA;
      abs_b  = b_neg ? -dataB : dataB;
   end

   // Shifted partial remainder needs one extra bit: it can exceed WIDTH bits for large divisors.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      fits      = (rem_shift >= {1'b0, div_q});
      rem_sub   = rem_shift[WIDTH-1:0] - div_q;
      rem_next  = fits ? rem_sub : rem_shift[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], fits};
      last      = (cnt_q == CntW'(WIDTH - 1));
      q_final   = qneg_q ? -quo_next : quo_next;
      r_final   = rneg_q ? -rem_next : rem_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (dz_pend_q || last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dz_pend_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  div_q     <= abs_b;
                  // A zero divisor reports the raw dividend as remainder.
                  quo_q     <= b_zero ? dataA : abs_a;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  qneg_q    <= a_neg ^ b_neg;
                  rneg_q    <= a_neg;
                  dz_pend_q <= b_zero;
               end
            end
            StBusy: begin
               if (dz_pend_q) begin
                  quotient_q  <= '1;
                  remainder_q <= quo_q;
                  dz_q        <= 1'b1;
               end else begin
                  rem_q <= rem_next;
                  quo_q <= quo_next;
                  cnt_q <= cnt_q + 1'b1;
                  if (last) begin
                     quotient_q  <= q_final;
                     remainder_q <= r_final;
                     dz_q        <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: per-cycle comparison against an arithmetic reference
// model, plus literal expectations for hand-computed division results and timing.
module tb_divider_seq;

   logic        clk = 1'b0;
   logic        rst, start, sign;
   logic [31:0] dataA, dataB;
   logic        busy, done, dz;
   logic [31:0] quotient, remainder;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   int done_cnt = 0;
   int busy_run = 0;
   int last_run = 0;

   // Reference model state
   bit          m_active = 1'b0;
   bit          m_done = 1'b0;
   int          m_cnt = 0;
   int          m_lat = 0;
   logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_dz = 1'b0, p_dz = 1'b0;

   divider_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .sign(sign), .dataA(dataA), .dataB(dataB),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
   );

   always #5 clk = ~clk;

   function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic z);
      longint sa, sb;
      if (b == 32'd0) begin
         q = '1; r = a; z = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
         z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] tq, tr;
      logic        tdz;
      if (rst) begin
         m_active <= 1'b0; m_done <= 1'b0;
         m_q <= '0; m_r <= '0; m_dz <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_active) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == m_lat) begin
            m_active <= 1'b0; m_done <= 1'b1;
            m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
         end
      end else if (start) begin
         ref_div(sign, dataA, dataB, tq, tr, tdz);
         p_q <= tq; p_r <= tr; p_dz <= tdz;
         m_lat <= (dataB == 32'd0) ? 1 : 32;
         m_cnt <= 0;
         m_active <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (busy !== (m_active | m_done) || done !== m_done || quotient !== m_q ||
             remainder !== m_r || dz !== m_dz) begin
            miscompares++;
            $display("FAIL cycle@%0t: busy=%b done=%b q=%h r=%h dz=%b, want busy=%b done=%b q=%h r=%h dz=%b",
                     $time, busy, done, quotient, remainder, dz,
                     m_active | m_done, m_done, m_q, m_r, m_dz);
         end
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_run++;
      else begin
         if (busy_run != 0) last_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one start cycle, then scramble the operands to show they are not re-sampled.
   task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; sign = s; dataA = a; dataB = b;
      @(negedge clk);
      start = 1'b0; sign = 1'($urandom); dataA = $urandom; dataB = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got no done after %0d cycles want done", n);
      end
   endtask

   task automatic run_op(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] wq, input logic [31:0] wr,
                         input logic wdz, input int wlat);
      int n;
      do_start(s, a, b);
      wait_done(n);
      chk({name, "_lat"}, 32'(n), 32'(wlat));
      chk({name, "_q"}, quotient, wq);
      chk({name, "_r"}, remainder, wr);
      chk({name, "_dz"}, {31'd0, dz}, {31'd0, wdz});
      @(negedge clk);
   endtask

   initial begin
      int n, d0;
      rst = 1'b1; start = 1'b0; sign = 1'b0; dataA = '0; dataB = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_q", quotient, 32'd0);
      chk("reset_r", remainder, 32'd0);
      chk("reset_dz", {31'd0, dz}, 32'd0);

      run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
      repeat (3) @(negedge clk);
      chk("busy_len", 32'(last_run), 32'd33);

      run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
      run_op("dz5", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 2);
      run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
      run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33);
      run_op("u_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 33);
      run_op("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 33);
      run_op("s_m8_3", 1'b1, 32'hFFFFFFF8, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 33);
      run_op("u_msb", 1'b0, 32'h80000000, 32'h80000001, 32'd0, 32'h80000000, 1'b0, 33);
      run_op("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 33);
      run_op("s_dz", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2);

      // Start pulse while busy must be ignored
      d0 = done_cnt;
      do_start(1'b0, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1; sign = 1'b0; dataA = 32'd50; dataB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("busy_start_q", quotient, 32'd14);
      chk("busy_start_r", remainder, 32'd2);
      repeat (3) @(negedge clk);
      chk("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Reset mid-operation aborts without a done pulse
      do_start(1'b0, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_q", quotient, 32'd0);
      chk("abort_r", remainder, 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_op("after_abort", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; all values in this document assume WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port sign, input, 1 bit: 1 = signed two's-complement (div), 0 = unsigned (divu); sampled with start.
REQ-006 The block SHALL have port dataA, input, WIDTH bits: the dividend.
REQ-007 The block SHALL have port dataB, input, WIDTH bits: the divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high in BUSY and DONE.
REQ-009 The block SHALL have port done, output, 1 bit: high for exactly one cycle when results become valid.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: registered quotient (LO).
REQ-011 The block SHALL have port remainder, output, WIDTH bits: registered remainder (HI).
REQ-012 The block SHALL have port dz, output, 1 bit: divide-by-zero flag for the last completed operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL latch the operand magnitudes, the result sign (sign & (dataA[31]^dataB[31])) and the remainder sign (sign & dataA[31]).
REQ-015 At that edge k it SHALL clear the 5-bit iteration counter and partial remainder, and go to BUSY.
REQ-016 In BUSY, each edge SHALL perform one restoring iteration: shift {rem,quo} left 1; if rem >= divisor magnitude, subtract it and set the quotient LSB.
REQ-017 The iteration with counter=31 SHALL be the last: at edge k+32 the sign-corrected quotient and remainder SHALL be registered and the FSM SHALL enter DONE.
REQ-018 In DONE, done SHALL be 1 for the whole cycle; at the next edge (k+33) the FSM SHALL return to IDLE and done SHALL fall.
REQ-019 If dataB=0 at the start edge, the FSM SHALL skip BUSY and enter DONE at edge k+1 with quotient=32'hFFFFFFFF, remainder=dataA (unmodified) and dz=1.
REQ-020 For every nonzero divisor, dz SHALL be 0 when results are registered.
REQ-021 Sign correction SHALL negate the quotient magnitude if the result sign is 1, and negate the remainder magnitude if the remainder sign is 1; the remainder therefore takes the dividend's sign.
REQ-022 For signed 32'h80000000 / 32'hFFFFFFFF, the results SHALL be quotient=32'h80000000 and remainder=0, with no flag and no special state.
REQ-023 start SHALL be ignored in BUSY and DONE: no restart and no operand relatch.
REQ-024 Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
REQ-025 quotient, remainder and dz SHALL hold their values from the last completed operation until the next DONE entry.
REQ-026 quotient and remainder SHALL NOT show intermediate values during BUSY.
REQ-027 dataA, dataB and sign MAY change after the start edge without affecting the result.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL go to IDLE and set counter=0, quotient=0, remainder=0, dz=0, busy=0 and done=0.
REQ-029 rst SHALL take priority over start and over any in-flight operation.
REQ-030 An operation aborted by reset SHALL produce no done pulse.

Verification
REQ-031 Unsigned: start, sign=0, 100/7 -> done high in the cycle after edge k+32, quotient=14, remainder=2, dz=0, busy high for 33 cycles.
REQ-032 Signed: start, sign=1, 32'hFFFFFFF9/2 (-7/2) -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
REQ-033 Divide by zero: 5/0 -> done after edge k+1, quotient=32'hFFFFFFFF, remainder=5, dz=1; the following 9/3 -> dz=0, quotient=3, remainder=0.
REQ-034 Signed overflow: 32'h80000000/32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, done at edge k+32.
REQ-035 Start while busy: pulse start with 50/5 at cycle k+10 of a 100/7 operation -> results are still 14 and 2, with exactly one done pulse.
REQ-036 Reset mid-operation: rst at cycle k+10 -> next cycle busy=0, quotient=0, remainder=0, and no done pulse; a fresh start then completes normally.
